// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared colour definitions for the RGB PWM sequencer: palette index type and duty codes.
// Latency: none (types, constants and a pure lookup function only).
// Backpressure: not applicable.
//
// Contents:
//   IDX_W        width of the palette index
//   color_e      palette index / sequencer state (IDX_OFF .. IDX_DIM_WHITE)
//   duty_code_e  symbolic duty level (OFF / HALF / FULL), mapped to a PWM width by the user
//   rgb_code_t   {r, g, b} duty codes for one palette entry
//   palette()    index -> rgb_code_t lookup
package rgb_pwm_sequencer_pkg;

   localparam int IDX_W = 3;

   typedef enum logic [IDX_W-1:0] {
      IDX_OFF       = 3'd0,
      IDX_RED       = 3'd1,
      IDX_GREEN     = 3'd2,
      IDX_BLUE      = 3'd3,
      IDX_YELLOW    = 3'd4,
      IDX_CYAN      = 3'd5,
      IDX_MAGENTA   = 3'd6,
      IDX_DIM_WHITE = 3'd7
   } color_e;

   typedef enum logic [1:0] {
      DUTY_OFF  = 2'd0,
      DUTY_HALF = 2'd1,
      DUTY_FULL = 2'd2
   } duty_code_e;

   typedef struct packed {
      duty_code_e r;
      duty_code_e g;
      duty_code_e b;
   } rgb_code_t;

   function automatic rgb_code_t palette(input color_e idx);
      rgb_code_t c;
      c = '{r: DUTY_OFF, g: DUTY_OFF, b: DUTY_OFF};
      case (idx)
         IDX_OFF:       c = '{r: DUTY_OFF,  g: DUTY_OFF,  b: DUTY_OFF };
         IDX_RED:       c = '{r: DUTY_FULL, g: DUTY_OFF,  b: DUTY_OFF };
         IDX_GREEN:     c = '{r: DUTY_OFF,  g: DUTY_FULL, b: DUTY_OFF };
         IDX_BLUE:      c = '{r: DUTY_OFF,  g: DUTY_OFF,  b: DUTY_FULL};
         IDX_YELLOW:    c = '{r: DUTY_FULL, g: DUTY_FULL, b: DUTY_OFF };
         IDX_CYAN:      c = '{r: DUTY_OFF,  g: DUTY_FULL, b: DUTY_FULL};
         IDX_MAGENTA:   c = '{r: DUTY_FULL, g: DUTY_OFF,  b: DUTY_FULL};
         IDX_DIM_WHITE: c = '{r: DUTY_HALF, g: DUTY_HALF, b: DUTY_HALF};
         default:       c = '{r: DUTY_OFF,  g: DUTY_OFF,  b: DUTY_OFF };
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rgb_pwm_sequencer_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer, rising-edge pulse.
// Latency: rise_pulse fires DEBOUNCE_CYCLES+2 edges after raw_in settles high.
// Backpressure: none; the pulse is single-cycle and must be consumed on that edge.
//
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   raw_in      asynchronous, bouncy button level (active high)
//   rise_pulse  one-cycle strobe, asserted on the edge where the accepted level goes 0->1
module rgb_pwm_sequencer_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic raw_in,
   output logic rise_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             differ;
   logic             accept;

   // cnt_q holds how many consecutive synchronized samples have disagreed with
   // level_q so far; the sample that would make it DEBOUNCE_CYCLES flips the level.
   assign differ = (sync2_q != level_q);
   assign accept = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

   // Combinational so the consumer can act on the same edge the level rises.
   assign rise_pulse = accept && !level_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         if (!differ) begin
            cnt_q <= '0;
         end else if (accept) begin
            level_q <= ~level_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED colour mixer front end: debounced SW2 steps an 8-entry palette, palette duties PWM the LEDs.
// Latency: COLOR_IDX updates on the debounced rise; duty loads 1 edge later, LEDs follow 1 edge after that.
// Backpressure: none; every accepted press advances the palette, the PWM counter free-runs.
//
// Ports:
//   CLK        system clock
//   RST_N      asynchronous active-low reset (clears all state, LEDs off, index 0)
//   SW2        raw push-button, active high, asynchronous and bouncy
//   LED_R/G/B  registered PWM outputs, 1 = lit
//   COLOR_IDX  current palette index
//
// Build option: define AUTO_CYCLE_EN to also advance the palette every AUTO_PERIOD cycles;
// a press restarts that interval, and a press coinciding with the interval end advances once.
module rgb_pwm_sequencer
   import rgb_pwm_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int PWM_BITS        = 8,
   parameter int AUTO_PERIOD     = 12000000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SW2,
   output logic             LED_R,
   output logic             LED_G,
   output logic             LED_B,
   output logic [IDX_W-1:0] COLOR_IDX
);

   // Elaboration-time parameter sanity checks.
   if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (PWM_BITS < 1) begin : g_chk_pwm
      $error("PWM_BITS must be at least 1");
   end
   if (AUTO_PERIOD < 2) begin : g_chk_auto
      $error("AUTO_PERIOD must be at least 2");
   end

   color_e              state_q;
   color_e              state_d;
   logic                press;
   logic                advance;
   rgb_code_t           code;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] duty_r_q;
   logic [PWM_BITS-1:0] duty_g_q;
   logic [PWM_BITS-1:0] duty_b_q;

   function automatic logic [PWM_BITS-1:0] code_to_duty(input duty_code_e c);
      logic [PWM_BITS-1:0] d;
      d = '0;
      case (c)
         DUTY_FULL: d = '1;
         DUTY_HALF: d[PWM_BITS-1] = 1'b1;
         default:   d = '0;
      endcase
      return d;
   endfunction

   rgb_pwm_sequencer_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .raw_in     (SW2),
      .rise_pulse (press)
   );

`ifdef AUTO_CYCLE_EN
   localparam int AUTO_W = $clog2(AUTO_PERIOD);

   logic [AUTO_W-1:0] auto_cnt_q;
   logic              auto_tc;

   assign auto_tc = (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1));
   // OR rather than add: a press on the terminal count still steps only once.
   assign advance = press | auto_tc;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         auto_cnt_q <= '0;
      end else if (advance) begin
         auto_cnt_q <= '0;
      end else begin
         auto_cnt_q <= auto_cnt_q + 1'b1;
      end
   end
`else
   assign advance = press;
`endif

   // Sequencer: one state per palette entry, stepping in order and wrapping 7 -> 0.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDX_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (advance) begin
         state_d = color_e'(state_q + 1'b1);
      end
   end

   assign COLOR_IDX = state_q;
   assign code      = palette(state_q);

   // Duty registers track the index one edge behind; the PWM counter is never
   // restarted, so a new colour takes effect from wherever the period currently is.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         duty_r_q  <= '0;
         duty_g_q  <= '0;
         duty_b_q  <= '0;
         pwm_cnt_q <= '0;
         LED_R     <= 1'b0;
         LED_G     <= 1'b0;
         LED_B     <= 1'b0;
      end else begin
         duty_r_q  <= code_to_duty(code.r);
         duty_g_q  <= code_to_duty(code.g);
         duty_b_q  <= code_to_duty(code.b);
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         // FULL is forced on: pwm_cnt < FULL alone would drop one cycle per period.
         LED_R     <= (duty_r_q == '1) | (pwm_cnt_q < duty_r_q);
         LED_G     <= (duty_g_q == '1) | (pwm_cnt_q < duty_g_q);
         LED_B     <= (duty_b_q == '1) | (pwm_cnt_q < duty_b_q);
      end
   end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer with DEBOUNCE_CYCLES=4, PWM_BITS=4, AUTO_PERIOD=64.
// Every cycle the DUT outputs are compared against a behavioural model; directed
// table rows and hand-written sequences add end-of-step index and duty checks.
module tb_rgb_pwm_sequencer;

   localparam int DEB  = 4;
   localparam int PB   = 4;
   localparam int AP   = 64;
   localparam int PER  = 1 << PB;
   localparam int FULL = PER - 1;
   localparam int HALF = PER / 2;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b0;
   logic       SW2   = 1'b0;
   logic       LED_R;
   logic       LED_G;
   logic       LED_B;
   logic [2:0] COLOR_IDX;

   int vectors     = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   rgb_pwm_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .PWM_BITS       (PB),
      .AUTO_PERIOD    (AP)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .SW2       (SW2),
      .LED_R     (LED_R),
      .LED_G     (LED_G),
      .LED_B     (LED_B),
      .COLOR_IDX (COLOR_IDX)
   );

   // Reference palette: OFF RED GREEN BLUE YELLOW CYAN MAGENTA DIM_WHITE
   int pal_r [8] = '{0, FULL, 0,    0,    FULL, 0,    FULL, HALF};
   int pal_g [8] = '{0, 0,    FULL, 0,    FULL, FULL, 0,    HALF};
   int pal_b [8] = '{0, 0,    0,    FULL, 0,    FULL, FULL, HALF};

   // ---------------- behavioural model ----------------
   bit sw_hist[$];    // button values not yet visible past the 2-cycle synchronizer
   bit seen_win[$];   // last DEB synchronized samples
   bit m_level;
   int m_idx;         // expected COLOR_IDX
   int m_duty_idx;    // palette entry the duty registers currently hold
   int m_edges;       // edges since reset release (PWM phase)
   int m_auto;        // cycles since last advance
   bit m_led_r, m_led_g, m_led_b;

   function automatic bit lit(input int duty, input int phase);
      return (duty == FULL) || (phase < duty);
   endfunction

   task automatic model_reset();
      sw_hist    = '{1'b0, 1'b0};
      seen_win.delete();
      m_level    = 1'b0;
      m_idx      = 0;
      m_duty_idx = 0;
      m_edges    = 0;
      m_auto     = 0;
      m_led_r    = 1'b0;
      m_led_g    = 1'b0;
      m_led_b    = 1'b0;
   endtask

   task automatic model_edge(input bit sw);
      bit seen;
      bit all_diff;
      bit press;
      bit adv;
      int phase;
      if (!RST_N) return;
      seen = sw_hist.pop_front();
      sw_hist.push_back(sw);
      seen_win.push_back(seen);
      if (seen_win.size() > DEB) void'(seen_win.pop_front());
      // accepted level flips once DEB consecutive samples all disagree with it
      all_diff = (seen_win.size() == DEB);
      foreach (seen_win[i]) if (seen_win[i] == m_level) all_diff = 1'b0;
      press = all_diff && !m_level;
      if (all_diff) m_level = !m_level;
      phase   = m_edges % PER;
      m_led_r = lit(pal_r[m_duty_idx], phase);
      m_led_g = lit(pal_g[m_duty_idx], phase);
      m_led_b = lit(pal_b[m_duty_idx], phase);
      m_duty_idx = m_idx;
      adv = press;
`ifdef AUTO_CYCLE_EN
      adv    = press || (m_auto == AP - 1);
      m_auto = adv ? 0 : m_auto + 1;
`endif
      if (adv) m_idx = (m_idx + 1) % 8;
      m_edges++;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("color_idx", int'(COLOR_IDX), m_idx);
      check("led_r", int'(LED_R), int'(m_led_r));
      check("led_g", int'(LED_G), int'(m_led_g));
      check("led_b", int'(LED_B), int'(m_led_b));
   endtask

   // drive while clock is low, model the rising edge, sample on the falling edge
   task automatic tick(input bit sw);
      SW2 = sw;
      @(posedge CLK);
      model_edge(sw);
      @(negedge CLK);
      check_outputs();
   endtask

   // asynchronous reset asserted mid-low-phase; outputs must clear immediately
   task automatic apply_reset();
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      check("async_rst_idx", int'(COLOR_IDX), 0);
      check("async_rst_leds", int'({LED_R, LED_G, LED_B}), 0);
      @(negedge CLK);
      repeat (3) tick(SW2);
      RST_N = 1'b1;
   endtask

   task automatic press_once();
      repeat (10) tick(1'b1);
      repeat (10) tick(1'b0);
   endtask

`ifndef AUTO_CYCLE_EN
   typedef struct {
      bit    sw;
      int    cycles;
      int    exp_idx;
      string name;
   } seg_t;

   seg_t tbl [21];
`endif

   initial begin
      model_reset();
      apply_reset();

`ifndef AUTO_CYCLE_EN
      // {SW2 level, cycles held, COLOR_IDX expected at end of row}
      tbl[0]  = '{sw: 1'b0, cycles: 40, exp_idx: 0, name: "reset_idle"};
      tbl[1]  = '{sw: 1'b1, cycles: 10, exp_idx: 1, name: "clean_press"};
      tbl[2]  = '{sw: 1'b0, cycles: 10, exp_idx: 1, name: "release"};
      tbl[3]  = '{sw: 1'b1, cycles: 1,  exp_idx: 1, name: "pulse1"};
      tbl[4]  = '{sw: 1'b0, cycles: 6,  exp_idx: 1, name: "after_pulse1"};
      for (int i = 0; i < 5; i++) begin
         tbl[5 + 2*i] = '{sw: 1'b1, cycles: 2, exp_idx: 1, name: "bounce_hi"};
         tbl[6 + 2*i] = '{sw: 1'b0, cycles: 2, exp_idx: 1, name: "bounce_lo"};
      end
      tbl[15] = '{sw: 1'b1, cycles: 10, exp_idx: 2, name: "bounce_settle"};
      tbl[16] = '{sw: 1'b0, cycles: 10, exp_idx: 2, name: "bounce_release"};
      tbl[17] = '{sw: 1'b1, cycles: 3,  exp_idx: 2, name: "pulse3"};
      tbl[18] = '{sw: 1'b0, cycles: 8,  exp_idx: 2, name: "after_pulse3"};
      tbl[19] = '{sw: 1'b1, cycles: 4,  exp_idx: 2, name: "pulse4"};
      tbl[20] = '{sw: 1'b0, cycles: 8,  exp_idx: 3, name: "after_pulse4"};

      for (int i = 0; i < 21; i++) begin
         repeat (tbl[i].cycles) tick(tbl[i].sw);
         check(tbl[i].name, int'(COLOR_IDX), tbl[i].exp_idx);
      end

      // wrap through the whole palette; dim white must be 50% on every channel
      apply_reset();
      for (int p = 1; p <= 8; p++) begin
         press_once();
         check("wrap_idx", int'(COLOR_IDX), p % 8);
         if (p == 7) begin
            int hr;
            int hg;
            int hb;
            hr = 0;
            hg = 0;
            hb = 0;
            repeat (PER) begin
               tick(1'b0);
               hr += int'(LED_R);
               hg += int'(LED_G);
               hb += int'(LED_B);
            end
            check("half_duty_r", hr, HALF);
            check("half_duty_g", hg, HALF);
            check("half_duty_b", hb, HALF);
         end
      end

      // async reset while the button is held at index 5
      apply_reset();
      repeat (4) press_once();
      begin
         int n;
         n = 0;
         while (COLOR_IDX != 3'd5 && n < 20) begin
            tick(1'b1);
            n++;
         end
         check("reach_idx5", int'(COLOR_IDX), 5);
      end
      repeat (2) tick(1'b1);
      apply_reset();
      repeat (10) tick(1'b1);
      check("held_after_reset", int'(COLOR_IDX), 1);
      repeat (10) tick(1'b0);
      check("held_release", int'(COLOR_IDX), 1);
`else
      // automatic stepping every AP cycles with no presses
      repeat (2 * AP + 2) tick(1'b0);
      check("auto_two_steps", int'(COLOR_IDX), 2);
      // schedule a press so the debounced rise lands on the terminal count
      begin
         int n;
         int start;
         n = 0;
         while (m_auto != AP - 6 && n < 2 * AP) begin
            tick(1'b0);
            n++;
         end
         start = m_idx;
         repeat (6) tick(1'b1);
         check("press_on_tc", int'(COLOR_IDX), (start + 1) % 8);
         tick(1'b1);
         check("press_on_tc_hold", int'(COLOR_IDX), (start + 1) % 8);
         repeat (10) tick(1'b0);
      end
`endif

      // randomized button activity against the model
      apply_reset();
      for (int s = 0; s < 80; s++) begin
         bit v;
         int len;
         v   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         repeat (len) tick(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
